// File: rtl/crc_checker.sv
// Serial receiver and CRC checker.
// A frame is DATA_WD data bits (LSB first, qualified by Data_Valid), an
// optional idle gap, then LFSR_WD CRC bits (LSB first, qualified by
// Crc_Valid). The CRC is recomputed over the data bits and compared bit by
// bit against the received CRC. Each frame ends with a one-cycle Done pulse,
// which carries the received byte and the verdict.
module crc_checker #(
  parameter int                 DATA_WD = 8,
  parameter int                 LFSR_WD = 8,
  parameter logic [LFSR_WD-1:0] SEED    = 8'hD8,
  parameter logic [LFSR_WD-1:0] TAPS    = 8'b0100_0100
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Data,
  input  logic               Data_Valid,
  input  logic               Crc_Valid,
  output logic [DATA_WD-1:0] Byte_Out,
  output logic               Done,
  output logic               Crc_Ok,
  output logic               Frame_Err
);

  localparam int MAX_WD = (DATA_WD > LFSR_WD) ? DATA_WD : LFSR_WD;
  localparam int CW     = $clog2(MAX_WD + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WD - 1);
  localparam logic [CW-1:0] CRC_LAST  = CW'(LFSR_WD - 1);

  typedef enum logic [1:0] {IDLE, DATA, WAIT_CRC, CRC} state_e;

  state_e             state_q, state_d;
  logic [LFSR_WD-1:0] lfsr_q, lfsr_d;
  logic [DATA_WD-1:0] shift_q, shift_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mis_q, mis_d;
  logic [DATA_WD-1:0] byte_q, byte_d;
  logic               done_q, done_d;
  logic               ok_q, ok_d;
  logic               ferr_q, ferr_d;
  logic               finish, abort;

  // One LFSR step for a data bit. The MSB takes the feedback directly;
  // lower bits take the shifted-down neighbour XOR the tapped feedback.
  function automatic logic [LFSR_WD-1:0] lfsrStep(input logic [LFSR_WD-1:0] r,
                                                  input logic d);
    logic               fb;
    logic [LFSR_WD-1:0] n;
    fb = d ^ r[0];
    n  = (r >> 1) ^ (TAPS & {LFSR_WD{fb}});
    n[LFSR_WD-1] = fb;
    return n;
  endfunction

  // Data bits enter at the top so the first bit ends up in bit 0.
  function automatic logic [DATA_WD-1:0] shiftIn(input logic [DATA_WD-1:0] s,
                                                 input logic d);
    logic [DATA_WD-1:0] n;
    n = s >> 1;
    n[DATA_WD-1] = d;
    return n;
  endfunction

  // Next-state logic: frame sequencing, LFSR/compare datapath and verdict.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    ferr_d  = ferr_q;
    finish  = 1'b0;
    abort   = 1'b0;

    case (state_q)
      IDLE: begin
        lfsr_d = SEED;
        mis_d  = 1'b0;
        cnt_d  = '0;
        if (Data_Valid) begin
          shift_d = shiftIn(shift_q, Data);
          lfsr_d  = lfsrStep(SEED, Data);
          if (DATA_WD == 1) begin
            state_d = WAIT_CRC;
          end else begin
            cnt_d   = CW'(1);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (Crc_Valid || !Data_Valid) begin
          abort = 1'b1;
        end else begin
          shift_d = shiftIn(shift_q, Data);
          lfsr_d  = lfsrStep(lfsr_q, Data);
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = WAIT_CRC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WAIT_CRC: begin
        if (Data_Valid) begin
          abort = 1'b1;
        end else if (Crc_Valid) begin
          mis_d  = mis_q | (Data != lfsr_q[0]);
          lfsr_d = lfsr_q >> 1;
          if (LFSR_WD == 1) begin
            finish = 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = CRC;
          end
        end
      end
      CRC: begin
        if (Data_Valid || !Crc_Valid) begin
          abort = 1'b1;
        end else begin
          mis_d  = mis_q | (Data != lfsr_q[0]);
          lfsr_d = lfsr_q >> 1;
          if (cnt_q == CRC_LAST) begin
            finish = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      done_d  = 1'b1;
      byte_d  = shift_q;
      ok_d    = ~mis_d;
      ferr_d  = 1'b0;
      state_d = IDLE;
      lfsr_d  = SEED;
      cnt_d   = '0;
      mis_d   = 1'b0;
    end

    if (abort) begin
      done_d  = 1'b1;
      ok_d    = 1'b0;
      ferr_d  = 1'b1;
      state_d = IDLE;
      lfsr_d  = SEED;
      cnt_d   = '0;
      mis_d   = 1'b0;
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      shift_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      ferr_q  <= ferr_d;
    end
  end

  assign Byte_Out  = byte_q;
  assign Done      = done_q;
  assign Crc_Ok    = ok_q;
  assign Frame_Err = ferr_q;

endmodule

// File: tb/tb_crc_checker.sv
// Directed testbench for crc_checker: good frames, corrupted CRC bits,
// framing aborts, mid-frame reset and back-to-back frames.
module tb_crc_checker;

  logic       Clk;
  logic       Rst;
  logic       Data;
  logic       Data_Valid;
  logic       Crc_Valid;
  logic [7:0] Byte_Out;
  logic       Done;
  logic       Crc_Ok;
  logic       Frame_Err;

  int total = 0;
  int bad   = 0;

  crc_checker dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Data       (Data),
    .Data_Valid (Data_Valid),
    .Crc_Valid  (Crc_Valid),
    .Byte_Out   (Byte_Out),
    .Done       (Done),
    .Crc_Ok     (Crc_Ok),
    .Frame_Err  (Frame_Err)
  );

  // Free-running clock, 10 ns period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference CRC: seed D8, each bit shifts right and XORs C4 (MSB
  // feedback plus taps 6 and 2) when data bit XOR LSB is one.
  function automatic logic [7:0] crcRef(input logic [7:0] d);
    logic [7:0] r;
    r = 8'hD8;
    for (int k = 0; k < 8; k++) begin
      if ((d[k] ^ r[0]) == 1'b1) r = (r >> 1) ^ 8'hC4;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  // Inputs change on the falling edge so the DUT samples them cleanly.
  task automatic driveBit(input logic dv, input logic cv, input logic d);
    @(negedge Clk);
    Data_Valid = dv;
    Crc_Valid  = cv;
    Data       = d;
  endtask

  task automatic sendData(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) driveBit(1'b1, 1'b0, v[i]);
  endtask

  task automatic sendCrc(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) driveBit(1'b0, 1'b1, v[i]);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) driveBit(1'b0, 1'b0, 1'b0);
  endtask

  // Full frame; returns at the falling edge where Done should be visible.
  task automatic runFrame(input logic [7:0] d, input logic [7:0] c, input int gap);
    sendData(d, 8);
    idleCycles(gap);
    sendCrc(c, 8);
    driveBit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    Rst = 1'b0; Data = 1'b0; Data_Valid = 1'b0; Crc_Valid = 1'b0;
    #1;
    total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", Done); end
    total++; if (Crc_Ok !== 1'b0) begin bad++; $display("[TB] FAIL reset_ok got=%b want=0", Crc_Ok); end
    total++; if (Frame_Err !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr got=%b want=0", Frame_Err); end
    total++; if (Byte_Out !== 8'h00) begin bad++; $display("[TB] FAIL reset_byte got=%h want=00", Byte_Out); end
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_good_frame;
    sendData(8'h00, 8);
    idleCycles(4);
    sendCrc(8'h14, 8);
    total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL good_early_done got=%b want=0", Done); end
    driveBit(1'b0, 1'b0, 1'b0);
    total++; if (Done !== 1'b1) begin bad++; $display("[TB] FAIL good_done got=%b want=1", Done); end
    total++; if (Byte_Out !== 8'h00) begin bad++; $display("[TB] FAIL good_byte got=%h want=00", Byte_Out); end
    total++; if (Crc_Ok !== 1'b1) begin bad++; $display("[TB] FAIL good_ok got=%b want=1", Crc_Ok); end
    total++; if (Frame_Err !== 1'b0) begin bad++; $display("[TB] FAIL good_ferr got=%b want=0", Frame_Err); end
    driveBit(1'b0, 1'b0, 1'b0);
    total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL good_done_pulse got=%b want=0", Done); end
    total++; if (Crc_Ok !== 1'b1) begin bad++; $display("[TB] FAIL good_ok_held got=%b want=1", Crc_Ok); end
  endtask

  task automatic test_bad_crc;
    runFrame(8'h00, 8'h15, 4);
    total++; if (Done !== 1'b1) begin bad++; $display("[TB] FAIL bit0_done got=%b want=1", Done); end
    total++; if (Crc_Ok !== 1'b0) begin bad++; $display("[TB] FAIL bit0_ok got=%b want=0", Crc_Ok); end
    total++; if (Frame_Err !== 1'b0) begin bad++; $display("[TB] FAIL bit0_ferr got=%b want=0", Frame_Err); end
    total++; if (Byte_Out !== 8'h00) begin bad++; $display("[TB] FAIL bit0_byte got=%h want=00", Byte_Out); end
    idleCycles(2);
    runFrame(8'h00, 8'h94, 4);
    total++; if (Done !== 1'b1) begin bad++; $display("[TB] FAIL bit7_done got=%b want=1", Done); end
    total++; if (Crc_Ok !== 1'b0) begin bad++; $display("[TB] FAIL bit7_ok got=%b want=0", Crc_Ok); end
    idleCycles(2);
  endtask

  task automatic test_abort_data;
    runFrame(8'h3C, crcRef(8'h3C), 1);
    total++; if (Crc_Ok !== 1'b1 || Byte_Out !== 8'h3C) begin bad++; $display("[TB] FAIL pre_abort_frame got=%b/%h want=1/3c", Crc_Ok, Byte_Out); end
    idleCycles(1);
    sendData(8'hFF, 5);
    driveBit(1'b0, 1'b0, 1'b0);
    total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL dvdrop_early got=%b want=0", Done); end
    driveBit(1'b0, 1'b0, 1'b0);
    total++; if (Done !== 1'b1) begin bad++; $display("[TB] FAIL dvdrop_done got=%b want=1", Done); end
    total++; if (Crc_Ok !== 1'b0) begin bad++; $display("[TB] FAIL dvdrop_ok got=%b want=0", Crc_Ok); end
    total++; if (Frame_Err !== 1'b1) begin bad++; $display("[TB] FAIL dvdrop_ferr got=%b want=1", Frame_Err); end
    total++; if (Byte_Out !== 8'h3C) begin bad++; $display("[TB] FAIL dvdrop_byte got=%h want=3c", Byte_Out); end
    idleCycles(2);
  endtask

  task automatic test_abort_crc;
    sendData(8'h00, 8);
    idleCycles(4);
    sendCrc(8'h14, 3);
    driveBit(1'b0, 1'b0, 1'b0);
    driveBit(1'b0, 1'b0, 1'b0);
    total++; if (Done !== 1'b1 || Frame_Err !== 1'b1 || Crc_Ok !== 1'b0) begin bad++; $display("[TB] FAIL cvdrop got=%b%b%b want=110", Done, Frame_Err, Crc_Ok); end
    idleCycles(1);
    sendData(8'h00, 8);
    idleCycles(2);
    driveBit(1'b1, 1'b0, 1'b1);
    driveBit(1'b0, 1'b0, 1'b0);
    total++; if (Done !== 1'b1 || Frame_Err !== 1'b1 || Crc_Ok !== 1'b0) begin bad++; $display("[TB] FAIL overrun got=%b%b%b want=110", Done, Frame_Err, Crc_Ok); end
    idleCycles(1);
    runFrame(8'h00, 8'h14, 4);
    total++; if (Done !== 1'b1 || Crc_Ok !== 1'b1 || Frame_Err !== 1'b0) begin bad++; $display("[TB] FAIL after_abort got=%b%b%b want=110", Done, Crc_Ok, Frame_Err); end
    idleCycles(2);
  endtask

  task automatic test_mid_reset;
    runFrame(8'hA5, crcRef(8'hA5), 2);
    total++; if (Crc_Ok !== 1'b1 || Byte_Out !== 8'hA5) begin bad++; $display("[TB] FAIL pre_reset_frame got=%b/%h want=1/a5", Crc_Ok, Byte_Out); end
    idleCycles(1);
    sendData(8'h00, 4);
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    Data_Valid = 1'b0;
    #1;
    total++; if (Byte_Out !== 8'h00 || Crc_Ok !== 1'b0 || Frame_Err !== 1'b0 || Done !== 1'b0) begin bad++; $display("[TB] FAIL midreset_outs got=%h/%b/%b/%b want=00/0/0/0", Byte_Out, Crc_Ok, Frame_Err, Done); end
    @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      driveBit(1'b0, 1'b0, 1'b0);
      total++; if (Done !== 1'b0) begin bad++; $display("[TB] FAIL midreset_nodone cyc=%0d got=%b want=0", i, Done); end
    end
    runFrame(8'h00, 8'h14, 4);
    total++; if (Done !== 1'b1 || Crc_Ok !== 1'b1 || Byte_Out !== 8'h00) begin bad++; $display("[TB] FAIL after_reset got=%b/%b/%h want=1/1/00", Done, Crc_Ok, Byte_Out); end
    idleCycles(2);
  endtask

  task automatic test_back_to_back;
    logic [7:0] dat [10];
    logic [7:0] nxt;
    int         doneCount;
    doneCount = 0;
    for (int f = 0; f < 10; f++) dat[f] = 8'($urandom_range(0, 255));
    nxt = dat[0];
    driveBit(1'b1, 1'b0, nxt[0]);
    for (int f = 0; f < 10; f++) begin
      nxt = dat[f];
      for (int i = 1; i < 8; i++) driveBit(1'b1, 1'b0, nxt[i]);
      idleCycles(f % 3);
      sendCrc(crcRef(dat[f]), 8);
      if (f < 9) begin
        nxt = dat[f + 1];
        driveBit(1'b1, 1'b0, nxt[0]);
      end else begin
        driveBit(1'b0, 1'b0, 1'b0);
      end
      if (Done === 1'b1) doneCount++;
      total++; if (Done !== 1'b1 || Crc_Ok !== 1'b1 || Frame_Err !== 1'b0 || Byte_Out !== dat[f]) begin bad++; $display("[TB] FAIL b2b_frame%0d got=%b/%b/%b/%h want=1/1/0/%h", f, Done, Crc_Ok, Frame_Err, Byte_Out, dat[f]); end
    end
    total++; if (doneCount != 10) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=10", doneCount); end
    idleCycles(2);
  endtask

  // Scenario sequence and final summary.
  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_abort_data();
    test_abort_crc();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
- Serial receiver and CRC checker. It is the receive-side counterpart of the serial 8-bit CRC LFSR generator.
- It consumes a frame in two phases:
  - DATA_WD data bits, LSB first, qualified by Data_Valid.
  - LFSR_WD CRC bits, LSB first, qualified by Crc_Valid.
- It recomputes the CRC over the data bits and compares it bit-by-bit against the received CRC.
- It presents the deserialized byte plus a pass/fail verdict. It sits at the link input, ahead of byte-level consumers.

Parameters:
- DATA_WD, 8, data bits per frame.
- LFSR_WD, 8, CRC width.
- SEED, 8'hD8, LFSR value loaded at reset and at the start of every frame.
- TAPS, 8'b0100_0100, feedback mask. Bit i set means fb is XORed into R[i].

Ports:
- Clk  in  1  clock; all sampling on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Data  in  1  serial bit; a data bit or a CRC bit depending on the qualifier.
- Data_Valid  in  1  high while Data carries a data bit.
- Crc_Valid  in  1  high while Data carries a CRC bit.
- Byte_Out  out  DATA_WD  received data; bit k is the k-th data bit received.
- Done  out  1  one-cycle pulse; frame finished, verdict valid.
- Crc_Ok  out  1  1 = all CRC bits matched and the frame was well-formed; held until the next Done.
- Frame_Err  out  1  1 = framing violation; held until the next Done.

Behaviour:
- Reset (Rst=0, async):
  - State=IDLE, R=SEED, counters=0.
  - Byte_Out=0, Done=0, Crc_Ok=0, Frame_Err=0.
  - Reset mid-frame discards the frame; no Done is issued.
- LFSR data step, per accepted data bit d:
  - fb = d ^ R[0].
  - R[LFSR_WD-1] <= fb.
  - R[i] <= R[i+1] ^ (TAPS[i] & fb) for i < LFSR_WD-1.
- CRC compare step, per accepted CRC bit:
  - mismatch |= (Data != R[0]).
  - R <= R >> 1, zero fill.
- FSM states: IDLE, DATA, WAIT_CRC, CRC.
- IDLE:
  - R=SEED, mismatch=0, cnt=0.
  - Data_Valid=1: absorb bit 0 into shift register and LFSR, cnt=1, go DATA.
  - DATA_WD=1 goes directly to WAIT_CRC.
  - Crc_Valid=1 alone: ignored.
- DATA:
  - Data_Valid=1: absorb bit, cnt++.
  - After the DATA_WD-th bit: cnt=0, go WAIT_CRC.
  - Data_Valid=0 before DATA_WD bits: abort.
  - Crc_Valid=1: abort.
- WAIT_CRC:
  - Idles indefinitely for the generator's turnaround gap.
  - Crc_Valid=1: compare the first CRC bit that cycle, cnt=1, go CRC.
  - Data_Valid=1: abort (overrun).
- CRC:
  - Crc_Valid=1: compare, cnt++.
  - After the LFSR_WD-th bit: finish.
  - Crc_Valid=0 early: abort.
  - Data_Valid=1: abort.
- Finish, registered at the edge that samples the last CRC bit, so visible the following cycle:
  - Done=1 for 1 cycle.
  - Byte_Out updated.
  - Crc_Ok = ~mismatch (including a mismatch on the final bit).
  - Frame_Err=0.
  - Go IDLE.
- Abort, registered:
  - Done=1 for 1 cycle, Crc_Ok=0, Frame_Err=1.
  - Byte_Out unchanged.
  - Go IDLE.
  - Data_Valid=1 on the aborting edge is not taken as a new frame start.
- Back-to-back frames: in IDLE, a frame whose first data bit arrives in the Done cycle is accepted. Latency from the last CRC bit to Done is 1 cycle.
- Data_Valid and Crc_Valid both high: treated as Data_Valid in IDLE; abort in every other state.
- Byte_Out, Crc_Ok and Frame_Err change only on Done.

Test Plan:
- Data 8'h00 sent LSB first, 4-cycle gap, then CRC 8'h14 LSB first (bits 0,0,1,0,1,0,0,0) -> Done pulses 1 cycle after the 8th CRC bit; Byte_Out=8'h00, Crc_Ok=1, Frame_Err=0.
- Same frame with CRC 8'h15 (bit 0 flipped) -> Done, Crc_Ok=0, Frame_Err=0, Byte_Out=8'h00. Repeat with bit 7 flipped (8'h94) -> Crc_Ok=0.
- Data_Valid dropped after 5 data bits -> Done next cycle, Crc_Ok=0, Frame_Err=1, Byte_Out keeps its previous value.
- Crc_Valid dropped after 3 CRC bits, and separately Data_Valid raised inside WAIT_CRC -> Done, Crc_Ok=0, Frame_Err=1; the following good 8'h00/8'h14 frame passes.
- Rst pulsed low after 4 data bits -> all outputs 0 immediately, no Done; the subsequent good frame passes with Crc_Ok=1.
- Ten frames back-to-back with random data, CRC from the reference model (SEED 8'hD8, TAPS 8'h44), next frame started in each Done cycle -> ten Done pulses, each Crc_Ok=1 and Byte_Out equal to the sent data.
